// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle MIPS core: fetch/decode/execute/memory/writeback with memory timeout.
// Optional performance counters are enabled by defining MULTICYCLE_PERF_CNT_EN.
module multicycle_control #(
  parameter int ALUOP_WIDTH = 3,
  parameter int MAX_WAIT    = 15
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_eq,
  output logic                   pc_write_ne,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [ALUOP_WIDTH-1:0] alu_op,
  output logic                   illegal_op,
  output logic                   bus_error,
  output logic [3:0]             state
`ifdef MULTICYCLE_PERF_CNT_EN
  ,
  output logic [31:0]            cycle_count,
  output logic [31:0]            instr_count
`endif
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_REXEC  = 4'd7,
    S_RWB    = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_ERROR  = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_OR    = 3'b101;
  localparam logic [2:0] ALU_AND   = 3'b110;
  localparam logic [2:0] ALU_LUI   = 3'b011;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  localparam logic [7:0] WAIT_LIM = 8'(MAX_WAIT);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [7:0] wait_q, wait_d;
  logic       illegal_q, illegal_d;
  logic       bus_err_q, bus_err_d;
  logic       mem_stall;

  function automatic logic [ALUOP_WIDTH-1:0] alu_code(input logic [2:0] c);
    return ALUOP_WIDTH'(c);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_INIT;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Memory states share one handshake: completion beats a timeout in the same cycle.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    mem_stall = 1'b0;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (wait_q == WAIT_LIM) begin
          state_d   = S_ERROR;
          bus_err_d = 1'b1;
        end else begin
          mem_stall = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = op;
        case (op)
          OP_R:                             state_d = S_REXEC;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_IEXEC;
          OP_LW, OP_SW:                     state_d = S_MEMADR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_J:                             state_d = S_JUMP;
          default: begin
            state_d   = S_ERROR;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_INIT;
    endcase
    wait_d = mem_stall ? (wait_q + 8'd1) : 8'd0;
  end

  always_comb begin
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_to_reg  = 1'b0;
    reg_dst     = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    pc_source   = 2'b00;
    alu_op      = '0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = 2'b01;
        alu_op    = alu_code(ALU_ADD);
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = alu_code(ALU_ADD);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = alu_code(ALU_ADD);
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_REXEC: begin
        alu_src_a = 1'b1;
        alu_op    = alu_code(ALU_RTYPE);
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op_q)
          OP_ANDI: alu_op = alu_code(ALU_AND);
          OP_ORI:  alu_op = alu_code(ALU_OR);
          OP_LUI:  alu_op = alu_code(ALU_LUI);
          default: alu_op = alu_code(ALU_ADD);
        endcase
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_op      = alu_code(ALU_SUB);
        pc_source   = 2'b01;
        pc_write_eq = (op_q == OP_BEQ);
        pc_write_ne = (op_q == OP_BNE);
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: ;
    endcase
  end

  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;
  assign state      = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        instr_done;

  // An instruction retires on the edge that carries its last state back to FETCH.
  assign instr_done = (state_d == S_FETCH) &&
                      (state_q inside {S_MEMWB, S_MEMWR, S_RWB, S_IWB, S_BRANCH, S_JUMP});

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != S_INIT && state_q != S_ERROR) cycle_cnt_d = cycle_cnt_q + 32'd1;
    if (instr_done) instr_cnt_d = instr_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_count = cycle_cnt_q;
  assign instr_count = instr_cnt_q;
`endif

endmodule
